load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit for the MEM stage: aligns store data onto byte lanes, extends
// load data, runs a single-outstanding bus handshake with a watchdog.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        exc_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [4:0] WD_LAST = 5'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [4:0]  wd_q;
  logic        ld_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        pending, is_load, fault, start, fault_now, timeout_hit;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] shifted, ld_sel;

  assign pending = mem_read_i | mem_write_i;
  assign is_load = mem_read_i;

  // Access decode: a simultaneous read and write is handled as a load.
  always_comb begin
    fault   = 1'b0;
    be_n    = 4'b1111;
    wdata_n = 32'h0;
    if (is_load) begin
      case (funct3_i)
        3'b000, 3'b100: fault = 1'b0;
        3'b001, 3'b101: fault = addr_i[0];
        3'b010:         fault = (addr_i[1:0] != 2'b00);
        default:        fault = 1'b1;
      endcase
    end else begin
      case (funct3_i)
        3'b000: begin
          be_n    = 4'b0001 << addr_i[1:0];
          wdata_n = {4{wdata_i[7:0]}};
        end
        3'b001: begin
          fault   = addr_i[0];
          be_n    = addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{wdata_i[15:0]}};
        end
        3'b010: begin
          fault   = (addr_i[1:0] != 2'b00);
          wdata_n = wdata_i;
        end
        default: fault = 1'b1;
      endcase
    end
  end

  assign start       = (state_q == IDLE) && pending && !fault;
  assign fault_now   = (state_q == IDLE) && pending && fault;
  assign timeout_hit = (state_q == REQ) && !bus_ack_i && (wd_q == WD_LAST);
  assign stall_o     = !reset && (start || (state_q == REQ));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     if (bus_ack_i || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane select uses the offset captured at issue, since bus_addr_o is aligned.
  always_comb begin
    shifted = bus_rdata_i >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_sel = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_sel = {24'h0, shifted[7:0]};
      3'b001:  ld_sel = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_sel = {16'h0, shifted[15:0]};
      default: ld_sel = bus_rdata_i;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wd_q        <= 5'd0;
      ld_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      rdata_o     <= 32'h0;
      exc_o       <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'h0;
      bus_wdata_o <= 32'h0;
      bus_be_o    <= 4'b0000;
    end else begin
      state_q <= state_d;
      exc_o   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= !is_load;
            bus_addr_o  <= {addr_i[31:2], 2'b00};
            bus_be_o    <= be_n;
            bus_wdata_o <= wdata_n;
            ld_q        <= is_load;
            f3_q        <= funct3_i;
            off_q       <= addr_i[1:0];
            wd_q        <= 5'd0;
          end else if (fault_now) begin
            exc_o <= 1'b1;
          end
        end
        REQ: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            if (ld_q) rdata_o <= ld_sel;
          end else if (timeout_hit) begin
            bus_req_o <= 1'b0;
            exc_o     <= 1'b1;
            if (ld_q) rdata_o <= 32'h0;
          end else begin
            wd_q <= wd_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses against a byte-level memory and access-rule reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o, exc_o, bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:255];
  int          ack_delay = 0;
  int          req_cnt   = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic [31:0] model_rdata = 32'h0;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .exc_o(exc_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  // Bus slave: acks after ack_delay idle REQ cycles, and toggles ack randomly
  // while no request is outstanding.
  always @(negedge clk) begin
    if (bus_req_o && !reset) begin
      if (req_cnt == 0) begin
        cap_addr = bus_addr_o; cap_wdata = bus_wdata_o;
        cap_be = bus_be_o; cap_we = bus_we_o;
      end else begin
        n_checks++;
        if ({bus_addr_o, bus_wdata_o, bus_be_o, bus_we_o} !== {cap_addr, cap_wdata, cap_be, cap_we}) begin
          n_fail++;
          $display("[TB] FAIL bus_stable: got %h/%h/%b/%b expected %h/%h/%b/%b",
                   bus_addr_o, bus_wdata_o, bus_be_o, bus_we_o, cap_addr, cap_wdata, cap_be, cap_we);
        end
      end
      if (req_cnt == ack_delay) begin
        logic [31:0] w;
        bus_ack_i   = 1'b1;
        w           = mem[bus_addr_o[9:2]];
        bus_rdata_i = w;
        if (bus_we_o) begin
          for (int k = 0; k < 4; k++)
            if (bus_be_o[k]) w[8*k +: 8] = bus_wdata_o[8*k +: 8];
          mem[bus_addr_o[9:2]] = w;
        end
      end else begin
        bus_ack_i   = 1'b0;
        bus_rdata_i = $urandom;
      end
      req_cnt++;
    end else begin
      req_cnt     = 0;
      bus_ack_i   = 1'($urandom_range(0, 1));
      bus_rdata_i = $urandom;
    end
  end

  // Reference: access size and fault from the instruction rules, lanes and
  // extension from byte arithmetic on the memory word.
  function automatic void predict(input logic rd, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input int delay,
                                  output bit fault, output bit tmo, output logic [3:0] be,
                                  output logic [31:0] wdata, output logic [31:0] rnext);
    int size, off;
    logic [31:0] v;
    fault = 0; size = 4; off = int'(a % 4);
    if (rd) begin
      if (f3 == 0 || f3 == 4) size = 1;
      else if (f3 == 1 || f3 == 5) size = 2;
      else if (f3 == 2) size = 4;
      else fault = 1;
    end else begin
      if (f3 == 0) size = 1;
      else if (f3 == 1) size = 2;
      else if (f3 == 2) size = 4;
      else fault = 1;
    end
    if (!fault && (a % size) != 0) fault = 1;
    tmo = (delay > 15);
    be = rd ? 4'hF : 4'(((1 << size) - 1) << off);
    wdata = 32'h0;
    if (!rd)
      for (int k = 0; k < 4; k++) wdata[8*k +: 8] = 8'((wd >> (8 * (k % size))) & 32'hFF);
    rnext = model_rdata;
    if (rd && !fault) begin
      if (tmo) rnext = 32'h0;
      else begin
        v = mem[a[9:2]] >> (8 * off);
        if (size == 1) begin
          rnext = v & 32'hFF;
          if (f3 == 0 && v[7]) rnext = rnext | 32'hFFFFFF00;
        end else if (size == 2) begin
          rnext = v & 32'hFFFF;
          if (f3 == 1 && v[15]) rnext = rnext | 32'hFFFF0000;
        end else rnext = mem[a[9:2]];
      end
    end
  endfunction

  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int delay,
                           output int stalls, output int excs, output int reqs);
    bit fin;
    logic st;
    ack_delay = delay;
    mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a; wdata_i = wd;
    stalls = 0; excs = 0; reqs = 0; fin = 0;
    for (int n = 0; n < 40 && !fin; n++) begin
      #1;
      if (exc_o) excs++;
      if (bus_req_o) reqs++;
      st = stall_o;
      if (st) stalls++;
      @(negedge clk);
      if (!st) fin = 1;
    end
    mem_read_i = 0; mem_write_i = 0;
    #1;
    if (exc_o) excs++;
    if (bus_req_o) reqs++;
    @(negedge clk);
    n_checks++;
    if (!fin) begin
      n_fail++;
      $display("[TB] FAIL access_done: got stall still high expected completion within 40 cycles");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h104;
    @(negedge clk); #1;
    n_checks++;
    if ({rdata_o, bus_addr_o, bus_wdata_o, bus_be_o} !== 100'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_regs: got %h %h %h %b expected zero", rdata_o, bus_addr_o, bus_wdata_o, bus_be_o);
    end
    n_checks++;
    if ({bus_req_o, bus_we_o, stall_o, exc_o} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {bus_req_o, bus_we_o, stall_o, exc_o});
    end
    mem_read_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_rdata = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_lw();
    int s, e, r;
    mem[32'h104 >> 2] = 32'hDEADBEEF;
    do_access(1, 0, 3'b010, 32'h104, 32'h0, 0, s, e, r);
    n_checks++;
    if (s !== 2) begin n_fail++; $display("[TB] FAIL lw_stall: got %0d expected 2", s); end
    n_checks++;
    if (rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL lw_rdata: got %h expected deadbeef", rdata_o); end
    n_checks++;
    if (cap_be !== 4'b1111 || e !== 0) begin n_fail++; $display("[TB] FAIL lw_be: got %b exc %0d expected 1111 exc 0", cap_be, e); end
    model_rdata = 32'hDEADBEEF;
  endtask

  task automatic test_lb_lbu();
    int s, e, r;
    mem[32'h103 >> 2] = 32'h80FF1234;
    do_access(1, 0, 3'b000, 32'h103, 32'h0, 1, s, e, r);
    n_checks++;
    if (rdata_o !== 32'hFFFFFF80) begin n_fail++; $display("[TB] FAIL lb_rdata: got %h expected ffffff80", rdata_o); end
    do_access(1, 0, 3'b100, 32'h103, 32'h0, 2, s, e, r);
    n_checks++;
    if (rdata_o !== 32'h00000080) begin n_fail++; $display("[TB] FAIL lbu_rdata: got %h expected 00000080", rdata_o); end
    model_rdata = 32'h00000080;
  endtask

  task automatic test_sh();
    int s, e, r;
    mem[32'h22 >> 2] = 32'h11223344;
    do_access(0, 1, 3'b001, 32'h22, 32'h0000ABCD, 1, s, e, r);
    n_checks++;
    if (cap_addr !== 32'h20 || cap_be !== 4'b1100) begin
      n_fail++; $display("[TB] FAIL sh_addr_be: got %h %b expected 00000020 1100", cap_addr, cap_be);
    end
    n_checks++;
    if (cap_wdata !== 32'hABCDABCD || cap_we !== 1'b1) begin
      n_fail++; $display("[TB] FAIL sh_wdata: got %h we %b expected abcdabcd we 1", cap_wdata, cap_we);
    end
    n_checks++;
    if (rdata_o !== 32'h00000080) begin n_fail++; $display("[TB] FAIL sh_rdata_hold: got %h expected 00000080", rdata_o); end
    n_checks++;
    if (mem[32'h22 >> 2] !== 32'hABCD3344) begin n_fail++; $display("[TB] FAIL sh_mem: got %h expected abcd3344", mem[32'h22 >> 2]); end
  endtask

  task automatic test_misaligned();
    int s, e, r;
    do_access(1, 0, 3'b010, 32'h102, 32'h0, 0, s, e, r);
    n_checks++;
    if (e !== 1 || r !== 0 || s !== 0) begin
      n_fail++; $display("[TB] FAIL misaligned: got exc %0d req %0d stall %0d expected 1 0 0", e, r, s);
    end
    n_checks++;
    if (rdata_o !== model_rdata) begin n_fail++; $display("[TB] FAIL misaligned_rdata: got %h expected %h", rdata_o, model_rdata); end
  endtask

  task automatic test_timeout();
    int s, e, r;
    do_access(1, 0, 3'b010, 32'h104, 32'h0, 20, s, e, r);
    n_checks++;
    if (r !== 16 || e !== 1 || s !== 17) begin
      n_fail++; $display("[TB] FAIL timeout: got req %0d exc %0d stall %0d expected 16 1 17", r, e, s);
    end
    n_checks++;
    if (rdata_o !== 32'h0) begin n_fail++; $display("[TB] FAIL timeout_rdata: got %h expected 0", rdata_o); end
    model_rdata = 32'h0;
    // Ack arriving in the final watchdog cycle wins over the timeout.
    do_access(1, 0, 3'b010, 32'h104, 32'h0, 15, s, e, r);
    n_checks++;
    if (r !== 16 || e !== 0 || rdata_o !== 32'hDEADBEEF) begin
      n_fail++; $display("[TB] FAIL ack_at_timeout: got req %0d exc %0d rdata %h expected 16 0 deadbeef", r, e, rdata_o);
    end
    model_rdata = 32'hDEADBEEF;
  endtask

  task automatic test_reset_mid();
    int s, e, r;
    ack_delay = 30;
    mem_read_i = 1; mem_write_i = 0; funct3_i = 3'b010; addr_i = 32'h104;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus_req_o, stall_o, exc_o} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_mid: got req/stall/exc %b expected 000", {bus_req_o, stall_o, exc_o});
    end
    mem_read_i = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_access(1, 0, 3'b010, 32'h104, 32'h0, 0, s, e, r);
    n_checks++;
    if (rdata_o !== 32'hDEADBEEF || e !== 0 || s !== 2) begin
      n_fail++; $display("[TB] FAIL after_reset_lw: got %h exc %0d stall %0d expected deadbeef 0 2", rdata_o, e, s);
    end
    model_rdata = 32'hDEADBEEF;
  endtask

  task automatic test_random();
    int s, e, r, delay, xs, xr;
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] a, wd, xwd, xrd;
    logic [3:0] xbe;
    bit fault, tmo;
    for (int i = 0; i < 80; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 1023));
      wd = $urandom;
      delay = ($urandom_range(0, 9) == 0) ? 15 + int'($urandom_range(0, 1)) * 5 : int'($urandom_range(0, 3));
      predict(rd, f3, a, wd, delay, fault, tmo, xbe, xwd, xrd);
      do_access(rd, wr, f3, a, wd, delay, s, e, r);
      xr = fault ? 0 : (tmo ? 16 : delay + 1);
      xs = fault ? 0 : xr + 1;
      n_checks++;
      if (s !== xs || r !== xr || e !== ((fault || tmo) ? 1 : 0)) begin
        n_fail++;
        $display("[TB] FAIL rand_ctrl[%0d]: got stall %0d req %0d exc %0d expected %0d %0d %0d",
                 i, s, r, e, xs, xr, (fault || tmo) ? 1 : 0);
      end
      n_checks++;
      if (rdata_o !== xrd) begin
        n_fail++; $display("[TB] FAIL rand_rdata[%0d]: got %h expected %h", i, rdata_o, xrd);
      end
      if (!fault) begin
        n_checks++;
        if (cap_addr !== {a[31:2], 2'b00} || cap_be !== xbe || cap_wdata !== xwd || cap_we !== !rd) begin
          n_fail++;
          $display("[TB] FAIL rand_bus[%0d]: got %h %b %h %b expected %h %b %h %b", i,
                   cap_addr, cap_be, cap_wdata, cap_we, {a[31:2], 2'b00}, xbe, xwd, !rd);
        end
      end
      model_rdata = xrd;
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_read_i = 0; mem_write_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    @(negedge clk);
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
